control_multiciclo: RTL and testbench

Multi-cycle main control FSM for the RV32I subset datapath: lw, sw, R-type (sub/xor/srl), addi and beq.
It replaces the single-cycle opcode decoder: it sequences one shared ALU and one shared memory over several cycles per instruction and drives all datapath enables.
Memory latency is a parameter, and unknown opcodes are flagged rather than decoded to X.
It sits between the instruction register's opcode field and the datapath muxes and enables.

---
 rtl/control_multiciclo.sv | 184 ++++++++++++++++++
 tb/tb_control_multiciclo.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/control_multiciclo.sv
// Multi-cycle main control FSM for the RV32I lw/sw/R-type/addi/beq datapath; memory states last MEM_WAIT+1 cycles.
// Optional jal support is enabled by defining CONTROL_JAL_EN.
module control_multiciclo #(
   parameter int OPCODE_W = 7,
   parameter int MEM_WAIT = 0,
   parameter int STATE_W  = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [OPCODE_W-1:0] Instrucaocontrole,
   input  logic                Zero,
   output logic                PCWrite,
   output logic                IRWrite,
   output logic                AdrSrc,
   output logic [1:0]          ALUSrcA,
   output logic [1:0]          ALUSrcB,
   output logic [1:0]          controlealuop,
   output logic [1:0]          ResultSrc,
   output logic                lermemControle,
   output logic                memoriaDeEscritaC,
   output logic                registradorDeEscritaC,
   output logic                ilegal,
   output logic [STATE_W-1:0]  estado
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECR    = 4'd6,
      S_ALUWB    = 4'd7,
      S_EXECI    = 4'd8,
`ifdef CONTROL_JAL_EN
      S_BEQ      = 4'd9,
      S_JAL      = 4'd10
`else
      S_BEQ      = 4'd9
`endif
   } state_t;

   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;
`ifdef CONTROL_JAL_EN
   localparam logic [6:0] OP_JAL = 7'b1101111;
`endif
   localparam logic [3:0] LAST_WAIT = 4'(MEM_WAIT);

   state_t     state_q, state_d;
   logic [3:0] cnt_q, cnt_d;
   logic [6:0] opcode;
   logic       last_wait;

   assign opcode    = 7'(Instrucaocontrole);
   assign last_wait = (cnt_q == LAST_WAIT);
   assign estado    = STATE_W'(state_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d               = state_q;
      cnt_d                 = '0;
      PCWrite               = 1'b0;
      IRWrite               = 1'b0;
      AdrSrc                = 1'b0;
      ALUSrcA               = 2'b00;
      ALUSrcB               = 2'b00;
      controlealuop         = 2'b00;
      ResultSrc             = 2'b00;
      lermemControle        = 1'b0;
      memoriaDeEscritaC     = 1'b0;
      registradorDeEscritaC = 1'b0;
      ilegal                = 1'b0;

      // Memory states hold until the counter reaches MEM_WAIT; leaving them leaves cnt_d at 0.
      case (state_q)
         S_FETCH: begin
            lermemControle = 1'b1;
            ALUSrcB        = 2'b10;
            ResultSrc      = 2'b10;
            if (last_wait) begin
               IRWrite = 1'b1;
               PCWrite = 1'b1;
               state_d = S_DECODE;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         S_DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_R:         state_d = S_EXECR;
               OP_I:         state_d = S_EXECI;
               OP_BEQ:       state_d = S_BEQ;
`ifdef CONTROL_JAL_EN
               OP_JAL:       state_d = S_JAL;
`endif
               default: begin
                  state_d = S_FETCH;
                  ilegal  = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
         end
         S_MEMREAD: begin
            AdrSrc         = 1'b1;
            lermemControle = 1'b1;
            if (last_wait) state_d = S_MEMWB;
            else           cnt_d   = cnt_q + 4'd1;
         end
         S_MEMWB: begin
            ResultSrc             = 2'b01;
            registradorDeEscritaC = 1'b1;
            state_d               = S_FETCH;
         end
         S_MEMWRITE: begin
            AdrSrc            = 1'b1;
            memoriaDeEscritaC = 1'b1;
            if (last_wait) state_d = S_FETCH;
            else           cnt_d   = cnt_q + 4'd1;
         end
         S_EXECR: begin
            ALUSrcA       = 2'b10;
            controlealuop = 2'b10;
            state_d       = S_ALUWB;
         end
         S_EXECI: begin
            ALUSrcA = 2'b10;
            ALUSrcB = 2'b01;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            registradorDeEscritaC = 1'b1;
            state_d               = S_FETCH;
         end
         S_BEQ: begin
            ALUSrcA       = 2'b10;
            controlealuop = 2'b01;
            PCWrite       = Zero;
            state_d       = S_FETCH;
         end
`ifdef CONTROL_JAL_EN
         S_JAL: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            PCWrite   = 1'b1;
            state_d   = S_ALUWB;
         end
`endif
         default: state_d = S_FETCH;
      endcase

      // No enable may fire during the reset cycle, whatever state is being abandoned.
      if (reset) begin
         PCWrite               = 1'b0;
         IRWrite               = 1'b0;
         lermemControle        = 1'b0;
         memoriaDeEscritaC     = 1'b0;
         registradorDeEscritaC = 1'b0;
         ilegal                = 1'b0;
      end
   end

endmodule

// File: tb/tb_control_multiciclo.sv
// Directed bench for control_multiciclo: three instances with MEM_WAIT = 0, 2 and 3.
module tb_control_multiciclo;

   logic       clk;
   logic       rst   [3];
   logic [6:0] op    [3];
   logic       zero  [3];
   logic       pcw   [3];
   logic       irw   [3];
   logic       adr   [3];
   logic [1:0] srca  [3];
   logic [1:0] srcb  [3];
   logic [1:0] aluop [3];
   logic [1:0] ressrc[3];
   logic       rd    [3];
   logic       wr    [3];
   logic       rw    [3];
   logic       il    [3];
   logic [3:0] est   [3];

   int n_assert = 0;
   int n_fail   = 0;

   // Vector order: PCWrite IRWrite AdrSrc ALUSrcA ALUSrcB aluop ResultSrc lermem memwrite regwrite ilegal
   localparam logic [14:0] E_FETCH_W = {1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0};
   localparam logic [14:0] E_FETCH_L = {1'b1, 1'b1, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0};
   localparam logic [14:0] E_DECODE  = {1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam logic [14:0] E_DEC_IL  = {1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1};
   localparam logic [14:0] E_MEMADR  = {1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam logic [14:0] E_MEMREAD = {1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
   localparam logic [14:0] E_MEMWB   = {1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0};
   localparam logic [14:0] E_MEMWR   = {1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0};
   localparam logic [14:0] E_EXECR   = {1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam logic [14:0] E_EXECI   = {1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam logic [14:0] E_ALUWB   = {1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
   localparam logic [14:0] E_BEQ_Z1  = {1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam logic [14:0] E_BEQ_Z0  = {1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef CONTROL_JAL_EN
   localparam logic [14:0] E_JAL     = {1'b1, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
   localparam logic [14:0] EN_MASK   = 15'b110_0000_0000_1111;

   control_multiciclo #(.OPCODE_W(7), .MEM_WAIT(0), .STATE_W(4)) u_dut0 (
      .clk(clk), .reset(rst[0]), .Instrucaocontrole(op[0]), .Zero(zero[0]),
      .PCWrite(pcw[0]), .IRWrite(irw[0]), .AdrSrc(adr[0]), .ALUSrcA(srca[0]), .ALUSrcB(srcb[0]),
      .controlealuop(aluop[0]), .ResultSrc(ressrc[0]), .lermemControle(rd[0]),
      .memoriaDeEscritaC(wr[0]), .registradorDeEscritaC(rw[0]), .ilegal(il[0]), .estado(est[0]));

   control_multiciclo #(.OPCODE_W(7), .MEM_WAIT(2), .STATE_W(4)) u_dut2 (
      .clk(clk), .reset(rst[1]), .Instrucaocontrole(op[1]), .Zero(zero[1]),
      .PCWrite(pcw[1]), .IRWrite(irw[1]), .AdrSrc(adr[1]), .ALUSrcA(srca[1]), .ALUSrcB(srcb[1]),
      .controlealuop(aluop[1]), .ResultSrc(ressrc[1]), .lermemControle(rd[1]),
      .memoriaDeEscritaC(wr[1]), .registradorDeEscritaC(rw[1]), .ilegal(il[1]), .estado(est[1]));

   control_multiciclo #(.OPCODE_W(7), .MEM_WAIT(3), .STATE_W(4)) u_dut3 (
      .clk(clk), .reset(rst[2]), .Instrucaocontrole(op[2]), .Zero(zero[2]),
      .PCWrite(pcw[2]), .IRWrite(irw[2]), .AdrSrc(adr[2]), .ALUSrcA(srca[2]), .ALUSrcB(srcb[2]),
      .controlealuop(aluop[2]), .ResultSrc(ressrc[2]), .lermemControle(rd[2]),
      .memoriaDeEscritaC(wr[2]), .registradorDeEscritaC(rw[2]), .ilegal(il[2]), .estado(est[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [14:0] outs(input int i);
      return {pcw[i], irw[i], adr[i], srca[i], srcb[i], aluop[i], ressrc[i], rd[i], wr[i], rw[i], il[i]};
   endfunction

   task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] expv);
      n_assert++;
      assert (obs === expv)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic st(input int i, input logic [3:0] es, input logic [14:0] ev, input string tag);
      chk({tag, "_estado"}, 15'(est[i]), 15'(es));
      chk(tag, outs(i), ev);
   endtask

   task automatic rst_chk(input int i, input logic [3:0] es, input string tag);
      chk({tag, "_estado"}, 15'(est[i]), 15'(es));
      chk({tag, "_enables"}, outs(i) & EN_MASK, 15'd0);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         rst[i]  = 1'b1;
         op[i]   = 7'b0000011;
         zero[i] = 1'b0;
      end

      // MEM_WAIT=0: reset held two cycles, then lw
      cyc(); rst_chk(0, 4'd0, "rst_c1");
      cyc(); rst_chk(0, 4'd0, "rst_c2");
      rst[0] = 1'b0; #1;
      st(0, 4'd0, E_FETCH_L, "lw_fetch");
      cyc(); st(0, 4'd1, E_DECODE,  "lw_decode");
      cyc(); st(0, 4'd2, E_MEMADR,  "lw_memadr");
      cyc(); st(0, 4'd3, E_MEMREAD, "lw_memread");
      cyc(); st(0, 4'd4, E_MEMWB,   "lw_memwb");
      cyc(); st(0, 4'd0, E_FETCH_L, "ill_fetch");

      // illegal opcode
      op[0] = 7'b1111111;
      cyc(); st(0, 4'd1, E_DEC_IL,  "ill_decode");
      cyc(); st(0, 4'd0, E_FETCH_L, "r_fetch");

      // R-type
      op[0] = 7'b0110011;
      cyc(); st(0, 4'd1, E_DECODE,  "r_decode");
      cyc(); st(0, 4'd6, E_EXECR,   "r_execr");
      cyc(); st(0, 4'd7, E_ALUWB,   "r_aluwb");
      cyc(); st(0, 4'd0, E_FETCH_L, "beq1_fetch");

      // beq taken then not taken
      op[0] = 7'b1100011; zero[0] = 1'b1;
      cyc(); st(0, 4'd1, E_DECODE,  "beq1_decode");
      cyc(); st(0, 4'd9, E_BEQ_Z1,  "beq1_beq");
      cyc(); st(0, 4'd0, E_FETCH_L, "beq0_fetch");
      zero[0] = 1'b0;
      cyc(); st(0, 4'd1, E_DECODE,  "beq0_decode");
      cyc(); st(0, 4'd9, E_BEQ_Z0,  "beq0_beq");
      cyc(); st(0, 4'd0, E_FETCH_L, "addi_fetch");

      // addi, with Zero toggled to show it is ignored outside BEQ
      op[0] = 7'b0010011; zero[0] = 1'b1;
      cyc(); st(0, 4'd1, E_DECODE,  "addi_decode");
      cyc(); st(0, 4'd8, E_EXECI,   "addi_execi");
      cyc(); st(0, 4'd7, E_ALUWB,   "addi_aluwb");
      cyc(); st(0, 4'd0, E_FETCH_L, "jal_fetch");

      op[0] = 7'b1101111; zero[0] = 1'b0;
`ifdef CONTROL_JAL_EN
      cyc(); st(0, 4'd1,  E_DECODE, "jal_decode");
      cyc(); st(0, 4'd10, E_JAL,    "jal_jal");
      cyc(); st(0, 4'd7,  E_ALUWB,  "jal_aluwb");
`else
      cyc(); st(0, 4'd1,  E_DEC_IL, "jal_illegal");
`endif
      cyc(); st(0, 4'd0, E_FETCH_L, "sw0_fetch");

      // sw with MEM_WAIT=0
      op[0] = 7'b0100011;
      cyc(); st(0, 4'd1, E_DECODE,  "sw0_decode");
      cyc(); st(0, 4'd2, E_MEMADR,  "sw0_memadr");
      cyc(); st(0, 4'd5, E_MEMWR,   "sw0_memwrite");
      cyc(); st(0, 4'd0, E_FETCH_L, "sw0_done");
      rst[0] = 1'b1;

      // MEM_WAIT=2: sw takes 8 cycles
      op[1] = 7'b0100011; rst[1] = 1'b0; #1;
      st(1, 4'd0, E_FETCH_W, "sw2_fetch_w0");
      cyc(); st(1, 4'd0, E_FETCH_W, "sw2_fetch_w1");
      cyc(); st(1, 4'd0, E_FETCH_L, "sw2_fetch_l");
      cyc(); st(1, 4'd1, E_DECODE,  "sw2_decode");
      cyc(); st(1, 4'd2, E_MEMADR,  "sw2_memadr");
      cyc(); st(1, 4'd5, E_MEMWR,   "sw2_memwr0");
      cyc(); st(1, 4'd5, E_MEMWR,   "sw2_memwr1");
      cyc(); st(1, 4'd5, E_MEMWR,   "sw2_memwr2");
      cyc(); st(1, 4'd0, E_FETCH_W, "sw2_next_fetch");
      rst[1] = 1'b1;

      // MEM_WAIT=3: lw interrupted by reset in MEMREAD
      op[2] = 7'b0000011; rst[2] = 1'b0; #1;
      st(2, 4'd0, E_FETCH_W, "lw3_fetch_w0");
      cyc(); st(2, 4'd0, E_FETCH_W, "lw3_fetch_w1");
      cyc(); st(2, 4'd0, E_FETCH_W, "lw3_fetch_w2");
      cyc(); st(2, 4'd0, E_FETCH_L, "lw3_fetch_l");
      cyc(); st(2, 4'd1, E_DECODE,  "lw3_decode");
      cyc(); st(2, 4'd2, E_MEMADR,  "lw3_memadr");
      cyc(); st(2, 4'd3, E_MEMREAD, "lw3_memread0");
      cyc(); st(2, 4'd3, E_MEMREAD, "lw3_memread1");
      rst[2] = 1'b1; #1;
      rst_chk(2, 4'd3, "lw3_rst_in_memread");
      cyc(); rst_chk(2, 4'd0, "lw3_rst_fetch");
      rst[2] = 1'b0; #1;
      st(2, 4'd0, E_FETCH_W, "lw3_rel_w0");
      cyc(); st(2, 4'd0, E_FETCH_W, "lw3_rel_w1");
      cyc(); st(2, 4'd0, E_FETCH_W, "lw3_rel_w2");
      cyc(); st(2, 4'd0, E_FETCH_L, "lw3_rel_l");
      cyc(); st(2, 4'd1, E_DECODE,  "lw3_rel_decode");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
